fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction fetch controller for the single-cycle ARMv8 core. Owns the program counter, drives the byte address of the combinational instruction memory, and registers each fetched 32-bit word into a one-entry output slot handed to decode with a valid/ready handshake. Handles branch redirects, back-pressure from decode, and latches a sticky fault on misaligned or out-of-range fetches.

## Interface
Parameters:
- MEM_SIZE, 64: instruction memory size in bytes; legal fetch addresses are 0..MEM_SIZE-4, word-aligned.
- RESET_PC, 0: PC value loaded on reset; must be word-aligned.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset; synchronous and active-high.
- i_start  input  1  leave IDLE and begin fetching.
- o_mem_add  output  64  byte address to the instruction memory; combinational copy of internal r_pc.
- i_mem_ins  input  32  instruction word returned combinationally by the memory for o_mem_add.
- o_valid  output  1  output slot holds an instruction.
- i_ready  input  1  decode accepts the slot this cycle.
- o_ins  output  32  registered instruction word.
- o_pc  output  64  address o_ins was fetched from.
- i_br_taken  input  1  redirect request.
- i_br_target  input  64  redirect byte address.
- o_fault  output  1  sticky fetch fault.
- o_fault_add  output  64  r_pc value that caused the fault.
- o_fetch_cnt  output  32  handshakes completed (see Configuration).
- o_stall_cnt  output  32  back-pressure cycles (see Configuration).

## Operation
- States: IDLE, FETCH, FAULT.
- Reset (any state, any cycle): state=IDLE, r_pc=RESET_PC, o_valid=0, o_ins=0, o_pc=0, o_fault=0, o_fault_add=0, counters=0. An in-flight instruction is discarded.
- IDLE: o_valid=0. i_br_taken is ignored. i_start=1 moves to FETCH next edge. r_pc is unchanged.
- FETCH, slot free, defined as o_valid==0 or (o_valid & i_ready):
  - Legal r_pc: o_ins<=i_mem_ins, o_pc<=r_pc, o_valid<=1, r_pc<=r_pc+4.
- FETCH, slot held (o_valid & !i_ready): o_ins, o_pc, o_valid and r_pc are all held.
- Fault check, applied only when the slot is free:
  - Fault condition: r_pc[1:0]!=0 or r_pc > MEM_SIZE-4 (unsigned 64-bit compare, no overflow path).
  - Response: state<=FAULT, o_fault<=1, o_fault_add<=r_pc, o_valid<=0.
  - If a handshake completes in the same cycle, that instruction is still consumed.
- Redirect, in FETCH: i_br_taken=1 has highest priority.
  - r_pc<=i_br_target and o_valid<=0, even if the slot is held. The held instruction is discarded and does not count as a handshake.
  - No fault check is made that cycle.
  - A bad target is accepted and faults on the next fetch attempt.
- FAULT: o_valid=0 and o_mem_add holds the faulting address. i_start and i_br_taken are ignored. Exit only via i_rst.
- Arithmetic: r_pc+4 is modulo 2^64. In practice wrap is unreachable because the range fault fires first.

## Timing
- Fetch latency: r_pc is presented in cycle N; the word appears on o_ins/o_valid in cycle N+1.
- Throughput: one instruction per cycle while i_ready=1.
- Start: i_start at edge E gives first o_valid=1 after edge E+1.
- Redirect penalty: i_br_taken in cycle N gives o_valid=0 in N+1 and the target instruction valid in N+2.
- Fault visibility: o_fault rises one cycle after the offending r_pc is presented with the slot free.

## Configuration
- FETCH_SEQ_PERF_EN defined:
  - o_fetch_cnt increments on each cycle with o_valid & i_ready & !i_br_taken.
  - o_stall_cnt increments on each FETCH cycle with o_valid & !i_ready.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- FETCH_SEQ_PERF_EN undefined: both ports are present but tied to 0 and no counter registers exist.

## Test plan
- Basic fetch: memory word0=0x8B020020, word1=0xCB030041. Apply reset, then i_start, with i_ready=1. Required: o_ins=0x8B020020/o_pc=0 and then 0x CB030041/o_pc=4 on consecutive cycles; o_mem_add steps 0,4,8.
- Back-pressure: drop i_ready for 3 cycles while o_valid=1. Required: o_ins/o_pc/o_mem_add frozen; o_stall_cnt=3 with the macro, 0 without.
- Redirect under stall: i_br_taken=1, target=0x10 while the slot is held. Required: o_valid=0 next cycle; o_pc=0x10 valid the cycle after; the discarded word is not counted in o_fetch_cnt.
- End of memory: run linearly with MEM_SIZE=64. Required: last valid o_pc=0x3C; then o_fault=1, o_fault_add=0x40, o_valid stays 0, and i_start/i_br_taken are ignored.
- Misaligned target: branch to 0x6. Required: o_fault=1, o_fault_add=0x6, no instruction delivered.
- Reset mid-run: assert i_rst while o_valid=1 in FETCH. Required: next cycle o_valid=0, o_fault=0, o_mem_add=RESET_PC, state IDLE until i_start.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch PC sequencer with one-entry output slot to decode
// Define FETCH_SEQ_PERF_EN to build the saturating fetch/stall performance counters.
module fetch_sequencer #(
  parameter int unsigned MEM_SIZE = 64,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic [63:0] o_mem_add,
  input  logic [31:0] i_mem_ins,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_ins,
  output logic [63:0] o_pc,
  input  logic        i_br_taken,
  input  logic [63:0] i_br_target,
  output logic        o_fault,
  output logic [63:0] o_fault_add,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [63:0] LAST_ADD = 64'(MEM_SIZE) - 64'd4;

  logic [1:0]  r_state;
  logic [63:0] r_pc;
  logic        slot_free;
  logic        pc_bad;

  assign o_mem_add = r_pc;
  assign slot_free = !o_valid || i_ready;
  // Unsigned compare against the last legal word: no wrap path reaches r_pc+4.
  assign pc_bad    = (r_pc[1:0] != 2'b00) || (r_pc > LAST_ADD);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      o_valid     <= 1'b0;
      o_ins       <= 32'd0;
      o_pc        <= 64'd0;
      o_fault     <= 1'b0;
      o_fault_add <= 64'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_valid <= 1'b0;
          if (i_start) begin
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (i_br_taken) begin
            // Redirect drops any held word and defers checking the target to the next attempt.
            r_pc    <= i_br_target;
            o_valid <= 1'b0;
          end else if (slot_free) begin
            if (pc_bad) begin
              r_state     <= ST_FAULT;
              o_fault     <= 1'b1;
              o_fault_add <= r_pc;
              o_valid     <= 1'b0;
            end else begin
              o_ins   <= i_mem_ins;
              o_pc    <= r_pc;
              o_valid <= 1'b1;
              r_pc    <= r_pc + 64'd4;
            end
          end
        end
        ST_FAULT: begin
          o_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (o_valid && i_ready && !i_br_taken && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if ((r_state == ST_FETCH) && o_valid && !i_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_fetch_cnt = 32'd0;
  assign o_stall_cnt = 32'd0;
`endif

endmodule
